// File: rtl/trena_uc_if.sv
// Handshake and debug signals between the tape-measure control unit and its datapath.
// master drives the requests and done pulses; slave is the control unit itself.
interface trena_uc_if;
    logic       medir;
    logic       pronto_medida;
    logic       pronto_serial;
    logic       zera;
    logic       mensurar;
    logic       partida_serial;
    logic [1:0] sel_letra;
    logic       pronto;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        output medir, pronto_medida, pronto_serial,
        input  zera, mensurar, partida_serial, sel_letra, pronto, timeout, db_estado
    );

    modport slave (
        input  medir, pronto_medida, pronto_serial,
        output zera, mensurar, partida_serial, sel_letra, pronto, timeout, db_estado
    );
endinterface

// File: rtl/trena_uc.sv
// Ultrasonic tape-measure control unit: one echo measurement then 4 UART chars; TRENA_UC_CONTINUO_EN adds auto-retrigger.
// Latency: medir sampled at edge k -> zera in cycle k+1 -> mensurar in k+2; per char 2 cycles + TX time.
// No backpressure: done pulses are only honoured in their wait states, medir only when idle/final/error.
module trena_uc #(
    parameter int unsigned TIMEOUT_CICLOS = 2_500_000,
    parameter int unsigned PERIODO_CICLOS = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    trena_uc_if.slave   bus
);

    typedef enum logic [3:0] {
        INICIAL       = 4'b0000,
        PREPARACAO    = 4'b0001,
        ENVIA_MEDIDA  = 4'b0010,
        ESPERA_MEDIDA = 4'b0011,
        TRANSMITE     = 4'b0100,
        ESPERA_SERIAL = 4'b0101,
        INCREMENTA    = 4'b0110,
        ERRO          = 4'b1110,
        FINAL         = 4'b1111
    } estado_t;

    localparam bit PARAMS_OK = (TIMEOUT_CICLOS >= 2) && (PERIODO_CICLOS >= 2);
    if (!PARAMS_OK) begin : g_bad_params
        $error("trena_uc: TIMEOUT_CICLOS and PERIODO_CICLOS must be >= 2");
    end

    localparam int unsigned WDW = $clog2(TIMEOUT_CICLOS);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CICLOS - 1);

    estado_t        state_q, state_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic [1:0]     char_q, char_d;
    logic           disparo;

`ifdef TRENA_UC_CONTINUO_EN
    localparam int unsigned PW = $clog2(PERIODO_CICLOS);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIODO_CICLOS - 1);

    logic [PW-1:0] per_q, per_d;

    // Saturating at the last value keeps the ">= period" trigger armed while idle.
    always_comb begin
        per_d = per_q;
        if (state_q == PREPARACAO) begin
            per_d = '0;
        end else if (per_q != PER_LAST) begin
            per_d = per_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    assign disparo = bus.medir | (per_q == PER_LAST);
`else
    assign disparo = bus.medir;
`endif

    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        char_d  = char_q;
        case (state_q)
            INICIAL, FINAL, ERRO: begin
                if (disparo) state_d = PREPARACAO;
            end
            PREPARACAO: begin
                char_d  = '0;
                wdog_d  = '0;
                state_d = ENVIA_MEDIDA;
            end
            ENVIA_MEDIDA: state_d = ESPERA_MEDIDA;
            ESPERA_MEDIDA: begin
                if (wdog_q != WD_LAST) wdog_d = wdog_q + 1'b1;
                // A late echo in the watchdog's last cycle still counts as a valid measurement.
                if (bus.pronto_medida) begin
                    state_d = TRANSMITE;
                end else if (wdog_q == WD_LAST) begin
                    state_d = ERRO;
                end
            end
            TRANSMITE: state_d = ESPERA_SERIAL;
            ESPERA_SERIAL: begin
                if (bus.pronto_serial) state_d = (char_q == 2'd3) ? FINAL : INCREMENTA;
            end
            INCREMENTA: begin
                char_d  = char_q + 1'b1;
                state_d = TRANSMITE;
            end
            default: state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= INICIAL;
            wdog_q  <= '0;
            char_q  <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            char_q  <= char_d;
        end
    end

    assign bus.zera           = (state_q == PREPARACAO);
    assign bus.mensurar       = (state_q == ENVIA_MEDIDA);
    assign bus.partida_serial = (state_q == TRANSMITE);
    assign bus.pronto         = (state_q == FINAL);
    assign bus.timeout        = (state_q == ERRO);
    assign bus.db_estado      = state_q;
    assign bus.sel_letra      = (state_q == TRANSMITE || state_q == ESPERA_SERIAL ||
                                 state_q == INCREMENTA) ? char_q : 2'd0;

endmodule

// File: tb/tb_trena_uc.sv
// Scoreboard bench for trena_uc: the stimulus side predicts every output event with its cycle,
// a negedge monitor pops and compares each event the DUT actually produces.
module tb_trena_uc;
    localparam int TO  = 100;
    localparam int PER = 500;

    typedef int four_t [4];
    typedef struct {
        logic [7:0] kind;
        int         sel;
        int         cyc;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];

    trena_uc_if bus();

    trena_uc #(.TIMEOUT_CICLOS(TO), .PERIODO_CICLOS(PER)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [3:0] db_of(input logic [7:0] k);
        case (k)
            "Z":     return 4'b0001;
            "M":     return 4'b0010;
            "P":     return 4'b0100;
            "D":     return 4'b1111;
            "T":     return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    // Monitor: one event per cycle at most, since every output is decoded from a distinct state.
    logic pronto_prev = 1'b0;
    logic timeout_prev = 1'b0;
    always @(negedge clock) begin
        logic [7:0] k;
        ev_t e;
        k = 8'd0;
        if (bus.zera)                           k = "Z";
        else if (bus.mensurar)                  k = "M";
        else if (bus.partida_serial)            k = "P";
        else if (bus.pronto && !pronto_prev)    k = "D";
        else if (bus.timeout && !timeout_prev)  k = "T";
        pronto_prev  = bus.pronto;
        timeout_prev = bus.timeout;
        if (k != 8'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=%s sel=%0d cyc=%0d required=none", k, bus.sel_letra, cyc);
            end else begin
                e = exp_q.pop_front();
                if (!(e.kind == k && e.sel == int'(bus.sel_letra) && e.cyc == cyc &&
                      bus.db_estado == db_of(k) && bus.pronto == (k == "D") && bus.timeout == (k == "T"))) begin
                    failures++;
                    $display("FAIL event actual=%s sel=%0d cyc=%0d db=%b pronto=%b timeout=%b required=%s sel=%0d cyc=%0d db=%b",
                             k, bus.sel_letra, cyc, bus.db_estado, bus.pronto, bus.timeout,
                             e.kind, e.sel, e.cyc, db_of(e.kind));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int all_outs();
        return int'({bus.zera, bus.mensurar, bus.partida_serial, bus.sel_letra,
                     bus.pronto, bus.timeout, bus.db_estado});
    endfunction

    // One measurement cycle. md: cycles from mensurar to pronto_medida (outside 1..TO means no echo).
    // sd[k]: cycles from partida_serial of char k to its pronto_serial. abort: reset while waiting on char 2.
    task automatic measure(input int md, input four_t sd, input bit noise, input bit abort);
        int  n, q, last, ac, c;
        int  p[4];
        int  r[4];
        bit  ok, pm, ps, mn;
        ev_t evs[$];
        n  = cyc;
        ok = (md >= 1 && md <= TO);
        q  = -1;
        ac = 0;
        evs.push_back('{"Z", 0, n + 1});
        evs.push_back('{"M", 0, n + 2});
        if (ok) begin
            q    = n + 2 + md;
            p[0] = q + 1;
            for (int k = 0; k < 4; k++) begin
                evs.push_back('{"P", k, p[k]});
                r[k] = p[k] + sd[k];
                if (k < 3) p[k+1] = r[k] + 2;
            end
            evs.push_back('{"D", 0, r[3] + 1});
            last = r[3] + 1;
            if (abort) begin
                ac   = p[2] + 1 + int'($urandom_range(0, sd[2] - 2));
                last = ac;
            end
        end else begin
            evs.push_back('{"T", 0, n + 3 + TO});
            last = n + 3 + TO;
        end
        foreach (evs[i]) if (ac == 0 || evs[i].cyc < ac) exp_q.push_back(evs[i]);

        bus.medir = 1'b1;
        tick();
        bus.medir = 1'b0;
        while (cyc < last) begin
            c  = cyc;
            pm = ok && (c == q);
            ps = ok && (c == r[0] || c == r[1] || c == r[2] || c == r[3]);
            mn = 1'b0;
            if (noise) begin
                mn = ($urandom_range(0, 7) == 0);
                if (!ok || c < q) ps = ps | ($urandom_range(0, 5) == 0);
                if (ok && c > q)  pm = pm | ($urandom_range(0, 5) == 0);
            end
            bus.medir         = mn;
            bus.pronto_medida = pm;
            bus.pronto_serial = ps;
            tick();
        end
        bus.medir         = 1'b0;
        bus.pronto_medida = 1'b0;
        bus.pronto_serial = 1'b0;

        if (ac != 0) begin
            reset = 1'b0;
            @(negedge clock);
            chk("rst_mid_outputs", all_outs(), 0);
            tick();
            tick();
            reset = 1'b1;
            repeat ($urandom_range(1, 5)) tick();
            @(negedge clock);
            chk("rst_release_idle_db", int'(bus.db_estado), 0);
        end else begin
            repeat ($urandom_range(0, 5)) tick();
            @(negedge clock);
            chk("end_hold", int'({bus.pronto, bus.timeout, bus.db_estado}),
                ok ? int'({1'b1, 1'b0, 4'b1111}) : int'({1'b0, 1'b1, 4'b1110}));
        end
        tick();
    endtask

    function automatic four_t rand_sd();
        four_t s;
        foreach (s[i]) s[i] = int'($urandom_range(2, 40));
        return s;
    endfunction

    initial begin
        bus.medir         = 1'b0;
        bus.pronto_medida = 1'b0;
        bus.pronto_serial = 1'b0;
        reset             = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", all_outs(), 0);
        reset = 1'b1;
        repeat (20) tick();
        @(negedge clock);
        chk("idle_inicial_db", int'(bus.db_estado), 0);
        tick();

        measure(30, '{50, 50, 50, 50}, 1'b0, 1'b0);
        measure(0, '{2, 2, 2, 2}, 1'b0, 1'b0);
        measure(30, rand_sd(), 1'b0, 1'b0);
        measure(TO, rand_sd(), 1'b1, 1'b0);
        measure(int'($urandom_range(1, TO)), '{20, 20, 25, 20}, 1'b1, 1'b1);
        measure(30, rand_sd(), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            measure(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO)),
                    rand_sd(), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
